// File: rtl/rsa_decrypt_core.sv
// Iterative RSA decryption core: plaintext = ct^d mod N_MOD, right-to-left square-and-multiply, one exponent bit per cycle.
// Optional macro RSA_DEC_EARLY_EXIT_EN stops exponentiation once no exponent bits remain.
module rsa_decrypt_core #(
  parameter int WIDTH = 8,
  parameter int N_MOD = 21,
  parameter int D_KEY = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             ct_valid,
  output logic             ct_ready,
  input  logic [WIDTH-1:0] ct_data,
  output logic             pt_valid,
  input  logic             pt_ready,
  output logic [WIDTH-1:0] pt_data,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0]   N_VEC    = WIDTH'(N_MOD);
  localparam logic [2*WIDTH-1:0] N_WIDE   = (2*WIDTH)'(N_MOD);
  localparam logic [WIDTH-1:0]   ONE_VEC  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_VEC = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   D_RESET  = WIDTH'(D_KEY);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] d_r, d_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] base_r, base_s;
  logic [WIDTH-1:0] ebits_r, ebits_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] pt_data_r, pt_data_s;
  logic [WIDTH-1:0] acc_step_s;
  logic             last_s;

  // Full double-width product reduced modulo N in the same cycle
  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = {ZERO_VEC, a} * {ZERO_VEC, b};
    return WIDTH'(prod % N_WIDE);
  endfunction

  function automatic logic [WIDTH-1:0] mod_red(input logic [WIDTH-1:0] a);
    return a % N_VEC;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      d_r       <= D_RESET;
      acc_r     <= ZERO_VEC;
      base_r    <= ZERO_VEC;
      ebits_r   <= ZERO_VEC;
      cnt_r     <= CNT_ZERO;
      pt_data_r <= ZERO_VEC;
    end else begin
      state_r   <= state_s;
      d_r       <= d_s;
      acc_r     <= acc_s;
      base_r    <= base_s;
      ebits_r   <= ebits_s;
      cnt_r     <= cnt_s;
      pt_data_r <= pt_data_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s    = state_r;
    d_s        = d_r;
    acc_s      = acc_r;
    base_s     = base_r;
    ebits_s    = ebits_r;
    cnt_s      = cnt_r;
    pt_data_s  = pt_data_r;
    acc_step_s = acc_r;
    last_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (key_load) begin
          d_s = key_in;
        end else begin
          d_s = d_r;
        end
        if (ct_valid) begin
          base_s  = mod_red(ct_data);
          acc_s   = mod_red(ONE_VEC);
          // A key loaded alongside the ciphertext already applies to it
          ebits_s = key_load ? key_in : d_r;
          cnt_s   = CNT_ZERO;
          state_s = EXP;
        end else begin
          state_s = IDLE;
        end
      end

      EXP: begin
        if (ebits_r[0]) begin
          acc_step_s = mod_mul(acc_r, base_r);
        end else begin
          acc_step_s = acc_r;
        end
        acc_s   = acc_step_s;
        base_s  = mod_mul(base_r, base_r);
        ebits_s = ebits_r >> 1;
        if (cnt_r != CNT_LAST) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
`ifdef RSA_DEC_EARLY_EXIT_EN
        last_s = (cnt_r == CNT_LAST) || (ebits_s == ZERO_VEC);
`else
        last_s = (cnt_r == CNT_LAST);
`endif
        if (last_s) begin
          pt_data_s = acc_step_s;
          state_s   = DONE;
        end else begin
          state_s   = EXP;
        end
      end

      DONE: begin
        if (pt_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign ct_ready = (state_r == IDLE) & ~rst;
  assign pt_valid = (state_r == DONE);
  assign busy     = (state_r == EXP) | (state_r == DONE);
  assign pt_data  = pt_data_r;

endmodule
